// File: rtl/result_serializer.sv
// result_serializer: LSB-first parallel-to-serial egress stage with valid/ready beats.
// Defining RESULT_SERIALIZER_PARITY_EN appends one even-parity beat to every word.
module result_serializer #(
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last
);
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           r_state;
  logic [WIDTH-2:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_data;
  logic             r_last;
  logic             w_beat;
  logic             w_last_data;
  logic             w_final;
  logic             w_load;
  // r_data is bit 0 of the word register; r_shift holds the bits still to come
  assign w_beat      = r_valid && ser_ready;
  assign w_last_data = r_state == SHIFT && r_cnt == CNT_W'(WIDTH - 1);
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic r_par;
  assign w_final = r_state == PARITY;
`else
  assign w_final = w_last_data;
`endif
  assign load_ready = r_state == IDLE || (w_final && ser_ready);
  assign w_load     = load_valid && load_ready;
  assign ser_valid  = r_valid;
  assign ser_data   = r_data;
  assign ser_last   = r_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= 1'b0;
      r_last  <= 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_load) begin
      r_state <= SHIFT;
      r_shift <= load_data[WIDTH-1:1];
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_data  <= load_data[0];
      r_last  <= 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      r_par   <= ^load_data;
`endif
    end else if (w_beat && r_state == SHIFT && !w_last_data) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_data  <= r_shift[0];
      r_last  <= !PAR_EN && r_cnt == CNT_W'(WIDTH - 2);
`ifdef RESULT_SERIALIZER_PARITY_EN
    end else if (w_beat && w_last_data) begin
      r_state <= PARITY;
      r_shift <= '0;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_data  <= r_par;
      r_last  <= 1'b1;
`endif
    end else if (w_beat) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_data  <= 1'b0;
      r_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: randomized scenarios checked against a word-to-beat-list model.
module tb_result_serializer;
  localparam int W = 31;
`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BEATS = W + PAR;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_data;
  logic         ser_last;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q_words[$];
  logic exp_d[$], exp_l[$], obs_d[$], obs_l[$];
  int n_stall_bad, n_gap, n_lr_busy, cyc_load0, cyc_first_v, cyc_last_acc;

  result_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_last(ser_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // Each word becomes its bits LSB first, plus the parity bit when enabled.
  function automatic void build_exp(input logic [W-1:0] ws[$]);
    exp_d.delete();
    exp_l.delete();
    foreach (ws[j]) begin
      for (int k = 0; k < W; k++) begin
        exp_d.push_back(ws[j][k]);
        exp_l.push_back(PAR == 0 && k == W - 1);
      end
      if (PAR != 0) begin
        exp_d.push_back(^ws[j]);
        exp_l.push_back(1'b1);
      end
    end
  endfunction

  // Feeds q_words and records accepted beats plus timing observations.
  task automatic drive(input int rmode, input bit lv_rand);
    int total, cyc;
    bit pv, pd, pl, pr, started;
    total = q_words.size() * BEATS;
    obs_d.delete();
    obs_l.delete();
    n_stall_bad = 0; n_gap = 0; n_lr_busy = 0;
    cyc_load0 = -1; cyc_first_v = -1; cyc_last_acc = -1;
    pv = 0; pd = 0; pl = 0; pr = 0; started = 0; cyc = 0;
    while (obs_d.size() < total && cyc < 5000) begin
      @(negedge clk);
      ser_ready  = (rmode == 0) || (rmode == 1 && cyc % 3 == 0) || (rmode == 2 && $urandom_range(1, 0) == 1);
      load_valid = q_words.size() != 0 && (!lv_rand || $urandom_range(1, 0) == 1);
      load_data  = q_words.size() != 0 ? q_words[0] : W'($urandom);
      #1;
      if (pv && !pr && ser_valid && (ser_data !== pd || ser_last !== pl)) n_stall_bad++;
      if (started && !ser_valid) n_gap++;
      if (ser_valid && load_ready) n_lr_busy++;
      if (ser_valid && cyc_first_v < 0) cyc_first_v = cyc;
      if (ser_valid && ser_ready) begin
        obs_d.push_back(ser_data);
        obs_l.push_back(ser_last);
        cyc_last_acc = cyc;
      end
      if (load_valid && load_ready) begin
        if (!started) cyc_load0 = cyc;
        started = 1;
        void'(q_words.pop_front());
      end
      pv = ser_valid; pd = ser_data; pl = ser_last; pr = ser_ready;
      cyc++;
    end
    @(negedge clk);
    load_valid = 0;
    ser_ready  = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; load_valid = 0; ser_ready = 0; load_data = '0;
    #12;
    vectors++;
    if ({ser_valid, ser_data, ser_last} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset outputs: got valid/data/last %b, want 000", {ser_valid, ser_data, ser_last});
    end
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset load_ready: got %b, want 1", load_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single;
    q_words = {31'h0000_0001};
    build_exp(q_words);
    drive(0, 0);
    for (int i = 0; i < exp_d.size(); i++) begin
      vectors++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL single beat %0d: got data/last %b/%b, want %b/%b", i,
                 i < obs_d.size() ? obs_d[i] : 1'bx, i < obs_l.size() ? obs_l[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    vectors++;
    if (cyc_first_v !== cyc_load0 + 1) begin
      miscompares++;
      $display("FAIL single latency: got first valid at cycle %0d, want %0d", cyc_first_v, cyc_load0 + 1);
    end
    vectors++;
    if (cyc_last_acc !== cyc_load0 + BEATS) begin
      miscompares++;
      $display("FAIL single last accept: got cycle %0d, want %0d", cyc_last_acc, cyc_load0 + BEATS);
    end
    #1;
    vectors++;
    if (ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single valid drop: got %b, want 0", ser_valid);
    end
  endtask

  task automatic test_backpressure;
    q_words = {31'h2AAA_AAAA};
    repeat (3) q_words.push_back(W'($urandom));
    build_exp(q_words);
    drive(1, 0);
    for (int i = 0; i < exp_d.size(); i++) begin
      vectors++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL backpressure beat %0d: got data/last %b/%b, want %b/%b", i,
                 i < obs_d.size() ? obs_d[i] : 1'bx, i < obs_l.size() ? obs_l[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    vectors++;
    if (n_stall_bad !== 0) begin
      miscompares++;
      $display("FAIL backpressure stability: got %0d changed stalled beats, want 0", n_stall_bad);
    end
  endtask

  task automatic test_back_to_back;
    q_words = {31'h7FFF_FFFF, 31'h0};
    repeat (2) q_words.push_back(W'($urandom));
    build_exp(q_words);
    drive(0, 0);
    for (int i = 0; i < exp_d.size(); i++) begin
      vectors++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL b2b beat %0d: got data/last %b/%b, want %b/%b", i,
                 i < obs_d.size() ? obs_d[i] : 1'bx, i < obs_l.size() ? obs_l[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    vectors++;
    if (n_gap !== 0) begin
      miscompares++;
      $display("FAIL b2b gap: got %0d idle cycles, want 0", n_gap);
    end
    vectors++;
    if (n_lr_busy !== 4) begin
      miscompares++;
      $display("FAIL b2b load_ready pulses: got %0d, want 4", n_lr_busy);
    end
    vectors++;
    if (cyc_last_acc - cyc_load0 !== 4 * BEATS) begin
      miscompares++;
      $display("FAIL b2b throughput: got %0d cycles, want %0d", cyc_last_acc - cyc_load0, 4 * BEATS);
    end
  endtask

  task automatic test_ignored_load;
    logic [W-1:0] word, junk;
    int inj;
    for (int r = 0; r < 2; r++) begin
      word = r == 0 ? 31'h7FFF_FFFF : W'($urandom);
      junk = r == 0 ? 31'h0 : W'($urandom);
      inj  = r == 0 ? 5 : $urandom_range(W - 2, 1);
      q_words = {word};
      build_exp(q_words);
      @(negedge clk);
      load_valid = 1; load_data = word; ser_ready = 1;
      @(negedge clk);
      for (int b = 0; b < BEATS; b++) begin
        load_valid = b == inj;
        load_data  = junk;
        #1;
        if (b == inj) begin
          vectors++;
          if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_load ready at beat %0d: got %b, want 0", b, load_ready);
          end
        end
        vectors++;
        if (ser_valid !== 1'b1 || ser_data !== exp_d[b] || ser_last !== exp_l[b]) begin
          miscompares++;
          $display("FAIL ignored_load beat %0d: got valid/data/last %b/%b/%b, want 1/%b/%b",
                   b, ser_valid, ser_data, ser_last, exp_d[b], exp_l[b]);
        end
        @(negedge clk);
      end
      load_valid = 0; ser_ready = 0;
      #1;
      vectors++;
      if (ser_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL ignored_load extra word: got valid %b, want 0", ser_valid);
      end
    end
  endtask

  task automatic test_reset_mid;
    q_words = {31'h2AAA_AAAA};
    build_exp(q_words);
    @(negedge clk);
    load_valid = 1; load_data = 31'h2AAA_AAAA; ser_ready = 1;
    @(negedge clk);
    load_valid = 0;
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (ser_valid !== 1'b1 || ser_data !== exp_d[10]) begin
      miscompares++;
      $display("FAIL reset_mid beat 10: got valid/data %b/%b, want 1/%b", ser_valid, ser_data, exp_d[10]);
    end
    #1 rst_n = 0;
    #1;
    vectors++;
    if ({ser_valid, ser_data, ser_last, load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got valid/data/last/ready %b, want 0001",
               {ser_valid, ser_data, ser_last, load_ready});
    end
    @(negedge clk);
    rst_n = 1; ser_ready = 0;
    q_words = {W'($urandom)};
    build_exp(q_words);
    drive(0, 0);
    for (int i = 0; i < exp_d.size(); i++) begin
      vectors++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL reset_mid next beat %0d: got data/last %b/%b, want %b/%b", i,
                 i < obs_d.size() ? obs_d[i] : 1'bx, i < obs_l.size() ? obs_l[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random;
    q_words.delete();
    repeat (16) q_words.push_back(W'($urandom));
    build_exp(q_words);
    drive(2, 1);
    for (int i = 0; i < exp_d.size(); i++) begin
      vectors++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL random beat %0d: got data/last %b/%b, want %b/%b", i,
                 i < obs_d.size() ? obs_d[i] : 1'bx, i < obs_l.size() ? obs_l[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    vectors++;
    if (n_stall_bad !== 0) begin
      miscompares++;
      $display("FAIL random stability: got %0d changed stalled beats, want 0", n_stall_bad);
    end
  endtask

`ifdef RESULT_SERIALIZER_PARITY_EN
  task automatic test_parity;
    q_words = {31'h7FFF_FFFF, 31'h0000_0003};
    drive(0, 0);
    vectors++;
    if (obs_d.size() != 2 * (W + 1) || obs_d[W] !== 1'b1 || obs_l[W] !== 1'b1 || obs_l[W-1] !== 1'b0) begin
      miscompares++;
      $display("FAIL parity ones word: got %0d beats, want %0d with parity/last 1/1", obs_d.size(), 2 * (W + 1));
    end
    vectors++;
    if (obs_d.size() != 2 * (W + 1) || obs_d[2*W+1] !== 1'b0 || obs_l[2*W+1] !== 1'b1) begin
      miscompares++;
      $display("FAIL parity word 3: got %0d beats, want parity beat data 0 last 1", obs_d.size());
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_ignored_load;
    test_reset_mid;
    test_random;
`ifdef RESULT_SERIALIZER_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
